// File: rtl/dpram_sync.sv
// Dual-port synchronous RAM: byte-addressed big-endian data port (R/W, byte strobes) and read-only fetch port.
// Optional per-byte even parity with error injection and sticky flag when DPRAM_PARITY_EN is defined.
module dpram_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    d_err_o,
    input  logic                    i_req_i,
    input  logic [ADDR_WIDTH-1:0]   i_addr_i,
    output logic                    i_rvalid_o,
    output logic [DATA_WIDTH-1:0]   i_rdata_o,
    output logic                    i_err_o
`ifdef DPRAM_PARITY_EN
    ,
    input  logic                    d_perr_inject_i,
    output logic                    perr_sticky_o
`endif
);
    localparam int NB       = DATA_WIDTH / 8;
    localparam int OFS      = (NB > 1) ? $clog2(NB) : 0;
    localparam int RAM_SIZE = 2 ** RAM_ADDR_WIDTH;
    localparam int WORDS    = RAM_SIZE / NB;
    localparam int IW       = RAM_ADDR_WIDTH - OFS;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [IW-1:0]         d_idx, i_idx;
    logic                  d_mis, i_mis;
    logic                  d_perr, i_perr;
    logic                  d_wr;

    assign d_idx = d_addr_i[RAM_ADDR_WIDTH-1:OFS];
    assign i_idx = i_addr_i[RAM_ADDR_WIDTH-1:OFS];

    generate
        if (OFS > 0) begin : g_align
            assign d_mis = |d_addr_i[OFS-1:0];
            assign i_mis = |i_addr_i[OFS-1:0];
        end else begin : g_noalign
            assign d_mis = 1'b0;
            assign i_mis = 1'b0;
        end
        // Upper address bits are intentionally ignored so the RAM aliases.
        if (ADDR_WIDTH > RAM_ADDR_WIDTH) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{d_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                                 i_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH]};
        end
    endgenerate

    assign d_wr = d_req_i && d_we_i && !d_mis;

`ifdef DPRAM_PARITY_EN
    logic [NB-1:0] par [WORDS];

    function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction

    assign d_perr = |(byte_par(mem[d_idx]) ^ par[d_idx]);
    assign i_perr = |(byte_par(mem[i_idx]) ^ par[i_idx]);

    always_ff @(posedge clk_i) begin
        if (rst_ni && d_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (d_be_i[b]) par[d_idx][b] <= (^d_wdata_i[8*b +: 8]) ^ d_perr_inject_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perr_sticky_o <= 1'b0;
        end else if ((d_req_i && !d_we_i && !d_mis && d_perr) || (i_req_i && !i_mis && i_perr)) begin
            perr_sticky_o <= 1'b1;
        end
    end
`else
    assign d_perr = 1'b0;
    assign i_perr = 1'b0;
`endif

    // Memory array carries no reset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (rst_ni && d_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (d_be_i[b]) mem[d_idx][8*b +: 8] <= d_wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            d_rvalid_o <= 1'b0;
            d_rdata_o  <= '0;
            d_err_o    <= 1'b0;
            i_rvalid_o <= 1'b0;
            i_rdata_o  <= '0;
            i_err_o    <= 1'b0;
        end else begin
            d_rvalid_o <= d_req_i;
            i_rvalid_o <= i_req_i;
            if (d_req_i) begin
                if (d_mis) begin
                    d_rdata_o <= '0;
                    d_err_o   <= 1'b1;
                end else if (d_we_i) begin
                    d_rdata_o <= '0;
                    d_err_o   <= 1'b0;
                end else begin
                    d_rdata_o <= mem[d_idx];
                    d_err_o   <= d_perr;
                end
            end
            if (i_req_i) begin
                if (i_mis) begin
                    i_rdata_o <= '0;
                    i_err_o   <= 1'b1;
                end else begin
                    i_rdata_o <= mem[i_idx];
                    i_err_o   <= i_perr;
                end
            end
        end
    end
endmodule

// File: tb/tb_dpram_sync.sv
// Self-checking bench for dpram_sync: directed scenarios plus randomized traffic against a byte-level model.
module tb_dpram_sync;
    logic        clk, rst_n;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
`ifdef DPRAM_PARITY_EN
    logic        d_perr_inject, perr_sticky;
`endif

    int total = 0;
    int bad = 0;
    byte unsigned ref_bytes [int];

    dpram_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
        .i_req_i(i_req), .i_addr_i(i_addr),
        .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata), .i_err_o(i_err)
`ifdef DPRAM_PARITY_EN
        , .d_perr_inject_i(d_perr_inject), .perr_sticky_o(perr_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Model: 64 KiB of bytes, word base is the lowest address, MSB lane first.
    function automatic int base_of(input logic [31:0] a);
        return int'(a & 32'h0000_FFFC);
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] be);
        int base = base_of(a);
        for (int i = 0; i < 4; i++) begin
            if (be[3-i]) ref_bytes[base + i] = data[31 - 8*i -: 8];
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r = 32'h0;
        int base = base_of(a);
        for (int i = 0; i < 4; i++) r = {r[23:0], ref_bytes[base + i]};
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; i_req = 1'b0;
    endtask

    task automatic drv_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] be);
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = data; d_be = be;
    endtask

    task automatic drv_read(input logic [31:0] a);
        d_req = 1'b1; d_we = 1'b0; d_addr = a; d_be = 4'h0;
    endtask

    task automatic drv_fetch(input logic [31:0] a);
        i_req = 1'b1; i_addr = a;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle();
        d_addr = '0; d_wdata = '0; i_addr = '0;
        step(); step();
        total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL reset_d_rvalid act=%b exp=0", d_rvalid); end
        total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL reset_d_rdata act=%h exp=0", d_rdata); end
        total++; if (d_err !== 1'b0) begin bad++; $display("FAIL reset_d_err act=%b exp=0", d_err); end
        total++; if (i_rvalid !== 1'b0) begin bad++; $display("FAIL reset_i_rvalid act=%b exp=0", i_rvalid); end
        total++; if (i_rdata !== 32'h0) begin bad++; $display("FAIL reset_i_rdata act=%h exp=0", i_rdata); end
        total++; if (i_err !== 1'b0) begin bad++; $display("FAIL reset_i_err act=%b exp=0", i_err); end
`ifdef DPRAM_PARITY_EN
        total++; if (perr_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky act=%b exp=0", perr_sticky); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        logic [31:0] exp;
        drv_write(32'h100, 32'h1122_3344, 4'hF); m_write(32'h100, 32'h1122_3344, 4'hF);
        step();
        total++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0})
            begin bad++; $display("FAIL write_ack act=%b/%b/%h exp=1/0/0", d_rvalid, d_err, d_rdata); end
        total++; if (i_rvalid !== 1'b0) begin bad++; $display("FAIL write_no_fetch act=%b exp=0", i_rvalid); end
        drv_read(32'h100); drv_fetch(32'h100);
        exp = m_read(32'h100);
        step();
        total++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, exp})
            begin bad++; $display("FAIL read_100 act=%b/%b/%h exp=1/0/%h", d_rvalid, d_err, d_rdata, exp); end
        total++; if ({i_rvalid, i_err, i_rdata} !== {2'b10, exp})
            begin bad++; $display("FAIL fetch_100 act=%b/%b/%h exp=1/0/%h", i_rvalid, i_err, i_rdata, exp); end
        idle();
        step();
        total++; if ({d_rvalid, d_rdata} !== {1'b0, exp})
            begin bad++; $display("FAIL idle_hold_d act=%b/%h exp=0/%h", d_rvalid, d_rdata, exp); end
        total++; if ({i_rvalid, i_rdata} !== {1'b0, exp})
            begin bad++; $display("FAIL idle_hold_i act=%b/%h exp=0/%h", i_rvalid, i_rdata, exp); end
    endtask

    task automatic test_strobes;
        logic [31:0] exp;
        drv_write(32'h100, 32'hAABB_CCDD, 4'b0101); m_write(32'h100, 32'hAABB_CCDD, 4'b0101);
        step();
        drv_read(32'h100);
        exp = m_read(32'h100);
        step();
        total++; if (d_rdata !== exp) begin bad++; $display("FAIL strobe_0101 act=%h exp=%h", d_rdata, exp); end
        drv_write(32'h100, 32'hFFFF_FFFF, 4'b0000);
        step();
        total++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0})
            begin bad++; $display("FAIL be0_ack act=%b/%b/%h exp=1/0/0", d_rvalid, d_err, d_rdata); end
        drv_read(32'h100);
        step();
        total++; if (d_rdata !== exp) begin bad++; $display("FAIL be0_nochange act=%h exp=%h", d_rdata, exp); end
        idle();
    endtask

    task automatic test_misalign;
        logic [31:0] exp;
        drv_write(32'h102, 32'h5555_5555, 4'hF);
        step();
        total++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0})
            begin bad++; $display("FAIL mis_write act=%b/%b/%h exp=1/1/0", d_rvalid, d_err, d_rdata); end
        drv_read(32'h100);
        exp = m_read(32'h100);
        step();
        total++; if ({d_err, d_rdata} !== {1'b0, exp})
            begin bad++; $display("FAIL mis_unchanged act=%b/%h exp=0/%h", d_err, d_rdata, exp); end
        drv_read(32'h103); drv_fetch(32'h101);
        step();
        total++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0})
            begin bad++; $display("FAIL mis_read act=%b/%b/%h exp=1/1/0", d_rvalid, d_err, d_rdata); end
        total++; if ({i_rvalid, i_err, i_rdata} !== {2'b11, 32'h0})
            begin bad++; $display("FAIL mis_fetch act=%b/%b/%h exp=1/1/0", i_rvalid, i_err, i_rdata); end
        idle();
    endtask

    task automatic test_collision;
        logic [31:0] old_v, new_v;
        drv_write(32'h200, 32'h0102_0304, 4'hF); m_write(32'h200, 32'h0102_0304, 4'hF);
        step();
        old_v = m_read(32'h200);
        drv_write(32'h200, 32'hDEAD_BEEF, 4'hF); drv_fetch(32'h200);
        m_write(32'h200, 32'hDEAD_BEEF, 4'hF);
        step();
        total++; if (i_rdata !== old_v) begin bad++; $display("FAIL collision_old act=%h exp=%h", i_rdata, old_v); end
        idle(); drv_fetch(32'h200);
        new_v = m_read(32'h200);
        step();
        total++; if (i_rdata !== new_v) begin bad++; $display("FAIL collision_new act=%h exp=%h", i_rdata, new_v); end
        idle();
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        drv_write(32'h204, 32'hA5A5_0F0F, 4'hF); m_write(32'h204, 32'hA5A5_0F0F, 4'hF);
        step();
        drv_read(32'h204);
        exp = m_read(32'h204);
        step();
        total++; if (d_rdata !== exp) begin bad++; $display("FAIL b2b_read act=%h exp=%h", d_rdata, exp); end
        drv_write(32'h0001_0200, 32'h1357_9BDF, 4'hF); m_write(32'h0001_0200, 32'h1357_9BDF, 4'hF);
        step();
        drv_read(32'h0000_0200); drv_fetch(32'hFFFF_0200);
        exp = m_read(32'h0000_0200);
        step();
        total++; if (d_rdata !== exp) begin bad++; $display("FAIL alias_read act=%h exp=%h", d_rdata, exp); end
        total++; if (i_rdata !== exp) begin bad++; $display("FAIL alias_fetch act=%h exp=%h", i_rdata, exp); end
        idle();
    endtask

    task automatic test_reset_mid;
        logic [31:0] exp;
        drv_read(32'h100);
        step();
        rst_n = 1'b0;
        drv_write(32'h100, 32'hCAFE_F00D, 4'hF); drv_fetch(32'h100);
        step();
        total++; if ({d_rvalid, i_rvalid} !== 2'b00)
            begin bad++; $display("FAIL rst_suppress act=%b%b exp=00", d_rvalid, i_rvalid); end
        total++; if ({d_rdata, i_rdata} !== 64'h0)
            begin bad++; $display("FAIL rst_clear act=%h/%h exp=0/0", d_rdata, i_rdata); end
        rst_n = 1'b1;
        idle(); drv_read(32'h100);
        exp = m_read(32'h100);
        step();
        total++; if ({d_rvalid, d_rdata} !== {1'b1, exp})
            begin bad++; $display("FAIL rst_retain act=%b/%h exp=1/%h", d_rvalid, d_rdata, exp); end
        idle();
    endtask

`ifdef DPRAM_PARITY_EN
    task automatic test_parity;
        logic [31:0] exp;
        d_perr_inject = 1'b1;
        drv_write(32'h300, 32'h1234_5678, 4'hF); m_write(32'h300, 32'h1234_5678, 4'hF);
        step();
        d_perr_inject = 1'b0;
        drv_read(32'h300);
        exp = m_read(32'h300);
        step();
        total++; if ({d_err, d_rdata} !== {1'b1, exp})
            begin bad++; $display("FAIL parity_err act=%b/%h exp=1/%h", d_err, d_rdata, exp); end
        total++; if (perr_sticky !== 1'b1) begin bad++; $display("FAIL parity_sticky act=%b exp=1", perr_sticky); end
        idle(); drv_read(32'h100); drv_fetch(32'h300);
        step();
        total++; if ({d_err, i_err, perr_sticky} !== 3'b011)
            begin bad++; $display("FAIL parity_mix act=%b%b%b exp=011", d_err, i_err, perr_sticky); end
        idle(); rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if (perr_sticky !== 1'b0) begin bad++; $display("FAIL parity_clear act=%b exp=0", perr_sticky); end
        drv_write(32'h300, 32'h1234_5678, 4'hF);
        step();
        drv_read(32'h300);
        step();
        total++; if ({d_err, perr_sticky} !== 2'b00)
            begin bad++; $display("FAIL parity_fixed act=%b%b exp=00", d_err, perr_sticky); end
        idle();
    endtask
`endif

    task automatic test_random;
        logic [31:0] ed_rdata, ei_rdata, a, fa, wd;
        logic        ed_err, ei_err, ed_v, ei_v, mis, fmis;
        logic [3:0]  be;
        rst_n = 1'b0; idle();
        step();
        rst_n = 1'b1;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            drv_write(32'h400 + 32'(w * 4), wd, 4'hF); m_write(32'h400 + 32'(w * 4), wd, 4'hF);
            step();
        end
        ed_rdata = 32'h0; ed_err = 1'b0; ei_rdata = 32'h0; ei_err = 1'b0;
        for (int n = 0; n < 300; n++) begin
            a  = 32'h400 + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            a  = a | ($urandom & 32'hFFFF_0000);
            fa = 32'h400 + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) fa = fa + 32'($urandom_range(1, 3));
            fa = fa | ($urandom & 32'hFFFF_0000);
            wd = $urandom; be = 4'($urandom);
            d_req = 1'($urandom); d_we = 1'($urandom); d_be = be; d_addr = a; d_wdata = wd;
            i_req = 1'($urandom); i_addr = fa;
            mis = (a[1:0] != 2'b00); fmis = (fa[1:0] != 2'b00);
            ed_v = d_req; ei_v = i_req;
            if (d_req) begin
                ed_err = mis;
                ed_rdata = (mis || d_we) ? 32'h0 : m_read(a);
            end
            if (i_req) begin
                ei_err = fmis;
                ei_rdata = fmis ? 32'h0 : m_read(fa);
            end
            if (d_req && d_we && !mis) m_write(a, wd, be);
            step();
            total++; if ({d_rvalid, d_err, d_rdata} !== {ed_v, ed_err, ed_rdata})
                begin bad++; $display("FAIL rand_d[%0d] act=%b/%b/%h exp=%b/%b/%h", n, d_rvalid, d_err, d_rdata, ed_v, ed_err, ed_rdata); end
            total++; if ({i_rvalid, i_err, i_rdata} !== {ei_v, ei_err, ei_rdata})
                begin bad++; $display("FAIL rand_i[%0d] act=%b/%b/%h exp=%b/%b/%h", n, i_rvalid, i_err, i_rdata, ei_v, ei_err, ei_rdata); end
        end
        idle();
    endtask

    initial begin
`ifdef DPRAM_PARITY_EN
        d_perr_inject = 1'b0;
`endif
        test_reset();
        test_write_read();
        test_strobes();
        test_misalign();
        test_collision();
        test_back_to_back();
        test_reset_mid();
`ifdef DPRAM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dpram_sync.md
Name: dpram_sync

Overview:
- Parametrised successor to the existing combinational dual-port RAM. Byte-addressed, big-endian shared memory with one read/write data port and one read-only instruction port.
- Differences from the existing RAM:
  - registered (1-cycle) reads with a valid pulse;
  - per-byte write strobes;
  - misalignment error reporting;
  - defined same-word collision behaviour.
- Sits between the core's LSU/IF stages and on-chip memory. Width and depth are set by parameters.

Parameters:
- DATA_WIDTH, 32: port data width in bits. Must be 8 × 2^k, with k ≥ 0.
- ADDR_WIDTH, 32: width of the byte address inputs.
- RAM_ADDR_WIDTH, 16: byte-address bits actually decoded. Depth = 2^RAM_ADDR_WIDTH bytes (local RAM_SIZE).
- Derived local NB = DATA_WIDTH/8 (bytes per word) and OFS = log2(NB) (offset bits).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  synchronous active-low reset.
- d_req_i  in  1  data-port request, sampled each cycle.
- d_we_i  in  1  1 = write, 0 = read.
- d_be_i  in  NB  byte strobes. Bit NB-1 selects the byte at word base, i.e. data bits [DW-1:DW-8].
- d_addr_i  in  ADDR_WIDTH  byte address.
- d_wdata_i  in  DATA_WIDTH  write data, big-endian.
- d_rvalid_o  out  1  one-cycle response pulse for every accepted request.
- d_rdata_o  out  DATA_WIDTH  read data. Valid with d_rvalid_o, otherwise held.
- d_err_o  out  1  error flag. Valid with d_rvalid_o.
- i_req_i  in  1  instruction fetch request.
- i_addr_i  in  ADDR_WIDTH  fetch byte address.
- i_rvalid_o  out  1  fetch response pulse.
- i_rdata_o  out  DATA_WIDTH  instruction word.
- i_err_o  out  1  fetch error flag. Valid with i_rvalid_o.

Behaviour:
- Reset (rst_ni = 0 at clk edge):
  - all outputs go to 0 (rvalid, rdata, err on both ports);
  - requests in that cycle are dropped and no memory write occurs;
  - memory contents are NOT cleared.
- Reset asserted while a response is due: the response is suppressed; no rvalid the next cycle.
- Address decode:
  - word index = addr[RAM_ADDR_WIDTH-1:OFS];
  - bits above RAM_ADDR_WIDTH are ignored, so addresses alias modulo RAM_SIZE.
- Alignment: addr[OFS-1:0] != 0 is misaligned (not applicable when NB = 1).
  - Response next cycle with err = 1 and rdata = 0.
  - Misaligned writes do not modify memory.
- Byte order: byte at word base maps to MSB lane, base+NB-1 to bits [7:0].
- Data write (req = 1, we = 1, aligned):
  - only lanes with be = 1 are updated at the edge;
  - next cycle d_rvalid_o = 1, d_err_o = 0, d_rdata_o = 0;
  - be = 0 is legal: no change, normal ack.
- Data read (req = 1, we = 0, aligned): next cycle d_rvalid_o = 1 and d_rdata_o = word contents at the request edge. d_be_i is ignored.
- Fetch (i_req_i = 1, aligned): next cycle i_rvalid_o = 1 with the word contents at the request edge.
- Both ports may issue a request every cycle. There is no back-pressure and latency is fixed at exactly 1.
- No request: rvalid = 0 next cycle, and rdata/err hold their last values.
- Collision: data write and fetch (or data read) to the same word in the same cycle.
  - The read returns OLD data (read-before-write).
  - The write completes; a read one cycle later returns new data.
- Back-to-back write then read of the same word on consecutive cycles: the read returns the written data.

Optional Feature:
- Macro DPRAM_PARITY_EN.
- When defined:
  - one even-parity bit is stored per byte and written with each strobed byte;
  - every read/fetch checks the parity of all NB bytes;
  - any mismatch sets that port's err = 1 with the data still returned;
  - extra input d_perr_inject_i (1 bit): when high on a write, the stored parity of the strobed bytes is inverted (test hook);
  - extra output perr_sticky_o (1 bit): set on any parity error, cleared only by reset.
- When undefined: no parity storage, no extra ports, and err reflects misalignment only.

Test Plan:
- Reset then write/read:
  - rst_ni = 0 for 2 cycles → all outputs 0;
  - write 0x11223344 to 0x100, be = 1111;
  - read 0x100 → next cycle d_rvalid_o = 1, d_rdata_o = 0x11223344;
  - fetch 0x100 → i_rdata_o = 0x11223344.
- Byte strobes: write 0xAABBCCDD to 0x100 with be = 0101 → read returns 0x11BB33DD.
- Misalignment:
  - write to 0x102 → d_err_o = 1 and memory unchanged;
  - read 0x100 still returns 0x11BB33DD;
  - fetch 0x101 → i_err_o = 1, i_rdata_o = 0.
- Collision:
  - same cycle: write 0xDEADBEEF to 0x200 and fetch 0x200 → i_rdata_o = old value;
  - next-cycle fetch → 0xDEADBEEF.
- Aliasing and reset mid-operation:
  - with RAM_ADDR_WIDTH = 16, a write to 0x10200 is read back at 0x0200;
  - assert rst_ni with a read pending → no d_rvalid_o, and memory is retained after reset.
- Parity (DPRAM_PARITY_EN defined): write with d_perr_inject_i = 1, then read → d_err_o = 1, perr_sticky_o = 1 until reset.
